// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for addsub_pipe; the pipeline drives the slave side.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             EN;
    logic             VALID_IN;
    logic             SUB;
    logic             CIN;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             VALID_OUT;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             V;
    logic             Z;

    modport master (
        output EN, VALID_IN, SUB, CIN, I0, I1,
        input  VALID_OUT, O, COUT, V, Z
    );

    modport slave (
        input  EN, VALID_IN, SUB, CIN, I0, I1,
        output VALID_OUT, O, COUT, V, Z
    );
endinterface

// File: rtl/addsub_pipe.sv
// Sliced, pipelined add/subtract: one SLICE-bit slice per stage, carry registered between stages.
// Define ADDSUB_PIPE_FLAGS_EN to register the overflow (V) and zero (Z) flags; otherwise they tie to 0.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic         CLK,
    input logic         RESET,
    addsub_pipe_if.slave bus
);
    localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;
    localparam int STAGES     = WIDTH / SAFE_SLICE;

    if ((SLICE < 1) || (WIDTH % SAFE_SLICE != 0)) begin : g_bad_cfg
        $fatal(1, "addsub_pipe: WIDTH must be a positive integer multiple of SLICE");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO    = k * SLICE;
        localparam int RW    = (k + 1) * SLICE;
        localparam int SRC_W = WIDTH - LO;

        // Operand bits not yet consumed arrive here; slice k is the low SLICE bits.
        logic [SRC_W-1:0] src_a;
        logic [SRC_W-1:0] src_b;
        logic             src_sub;
        logic             src_c;
        logic             src_valid;
        logic [SLICE-1:0] b_eff;
        logic [SLICE:0]   sum;
        logic [RW-1:0]    res_new;
        logic [RW-1:0]    res_d, res_q;
        logic             carry_d, carry_q;
        logic             valid_d, valid_q;

        if (k == 0) begin : g_src
            always_comb begin
                src_a     = bus.I0;
                src_b     = bus.I1;
                src_sub   = bus.SUB;
                src_c     = bus.CIN ^ bus.SUB;
                src_valid = bus.VALID_IN;
                res_new   = sum[SLICE-1:0];
            end
        end else begin : g_src
            always_comb begin
                src_a     = g_stage[k-1].g_ops.a_q;
                src_b     = g_stage[k-1].g_ops.b_q;
                src_sub   = g_stage[k-1].g_ops.sub_q;
                src_c     = g_stage[k-1].carry_q;
                src_valid = g_stage[k-1].valid_q;
                res_new   = {sum[SLICE-1:0], g_stage[k-1].res_q};
            end
        end

        // NOTE: each _d is assigned on every path (EN=0 selects the _q), so no latch is inferred.
        always_comb begin
            b_eff   = src_b[SLICE-1:0] ^ {SLICE{src_sub}};
            sum     = {1'b0, src_a[SLICE-1:0]} + {1'b0, b_eff} + {{SLICE{1'b0}}, src_c};
            res_d   = bus.EN ? res_new   : res_q;
            carry_d = bus.EN ? sum[SLICE] : carry_q;
            valid_d = bus.EN ? src_valid : valid_q;
        end

        // NOTE: non-blocking updates; data registers are reset too so O/COUT read 0 after reset.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                res_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                res_q   <= res_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            localparam int REM = SRC_W - SLICE;

            logic [REM-1:0] a_d, a_q;
            logic [REM-1:0] b_d, b_q;
            logic           sub_d, sub_q;

            always_comb begin
                a_d   = bus.EN ? src_a[SRC_W-1:SLICE] : a_q;
                b_d   = bus.EN ? src_b[SRC_W-1:SLICE] : b_q;
                sub_d = bus.EN ? src_sub : sub_q;
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    sub_q <= sub_d;
                end
            end
        end else begin : g_tail
            assign bus.O         = res_q;
            assign bus.COUT      = carry_q;
            assign bus.VALID_OUT = valid_q;

`ifdef ADDSUB_PIPE_FLAGS_EN
            logic v_d, v_q;
            logic z_d, z_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_comb begin
                v_d = bus.EN ? (src_a[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1] ^ sum[SLICE]) : v_q;
                z_d = bus.EN ? (res_new == '0) : z_q;
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    v_q <= 1'b0;
                    z_q <= 1'b0;
                end else begin
                    v_q <= v_d;
                    z_q <= z_d;
                end
            end

            assign bus.V = v_q;
            assign bus.Z = z_q;
`else
            assign bus.V = 1'b0;
            assign bus.Z = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=16, SLICE=4, latency 4); flag expectations follow ADDSUB_PIPE_FLAGS_EN.
module tb_addsub_pipe;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
`ifdef ADDSUB_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    localparam int NVEC = 9;
    localparam vec_t TBL [NVEC] = '{
        '{1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFD, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b1, 16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0}
    };

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic sub, input logic cin,
                         input logic [15:0] a, input logic [15:0] b);
        bus.VALID_IN = valid;
        bus.SUB      = sub;
        bus.CIN      = cin;
        bus.I0       = a;
        bus.I1       = b;
    endtask

    // Issues one op into an idle pipe and samples the outputs 3 and 4 edges later.
    task automatic run_op(input logic sub, input logic cin, input logic [15:0] a, input logic [15:0] b,
                          output logic early, output logic vld, output logic [15:0] o,
                          output logic c, output logic v, output logic z);
        drive(1'b1, sub, cin, a, b);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        early = bus.VALID_OUT;
        tick();
        vld = bus.VALID_OUT;
        o   = bus.O;
        c   = bus.COUT;
        v   = bus.V;
        z   = bus.Z;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.EN = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h5555);
        tick();
        tick();
        checks++;
        if ({bus.VALID_OUT, bus.O, bus.COUT, bus.V, bus.Z} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b o=%h c=%b v=%b z=%b want all 0",
                     bus.VALID_OUT, bus.O, bus.COUT, bus.V, bus.Z);
        end
        rst    = 1'b0;
        bus.EN = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.VALID_OUT !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop[%0d]: got valid=%b want 0", i, bus.VALID_OUT);
            end
        end
    endtask

    task automatic test_arith();
        logic early, vld, c, v, z;
        logic [15:0] o;
        for (int i = 0; i < NVEC; i++) begin
            run_op(TBL[i].sub, TBL[i].cin, TBL[i].a, TBL[i].b, early, vld, o, c, v, z);
            checks++;
            if (early !== 1'b0 || vld !== 1'b1) begin
                errors++;
                $display("FAIL arith[%0d] latency: got valid@3=%b valid@4=%b want 0/1", i, early, vld);
            end
            checks++;
            if ({c, o} !== {TBL[i].c, TBL[i].o}) begin
                errors++;
                $display("FAIL arith[%0d] result: got cout=%b o=%h want cout=%b o=%h",
                         i, c, o, TBL[i].c, TBL[i].o);
            end
            checks++;
            if ({v, z} !== {FLAGS & TBL[i].v, FLAGS & TBL[i].z}) begin
                errors++;
                $display("FAIL arith[%0d] flags: got v=%b z=%b want v=%b z=%b",
                         i, v, z, FLAGS & TBL[i].v, FLAGS & TBL[i].z);
            end
        end
    endtask

    task automatic test_stall_hold();
        logic early, vld, c, v, z;
        logic [15:0] o;
        run_op(1'b0, 1'b0, 16'h0F0F, 16'h00F1, early, vld, o, c, v, z);
        checks++;
        if ({vld, c, o} !== {1'b1, 1'b0, 16'h1000}) begin
            errors++;
            $display("FAIL stall_pre: got valid=%b cout=%b o=%h want 1 0 1000", vld, c, o);
        end
        bus.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.VALID_OUT, bus.COUT, bus.O} !== {1'b1, 1'b0, 16'h1000}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b cout=%b o=%h want 1 0 1000",
                         i, bus.VALID_OUT, bus.COUT, bus.O);
            end
        end
        bus.EN = 1'b1;
        tick();
        checks++;
        if (bus.VALID_OUT !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got valid=%b want 0", bus.VALID_OUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want_o [4] = '{16'h0002, 16'h0100, 16'h1000, 16'h0000};
        logic        want_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        want_z [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001);
        tick();
        bus.EN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.VALID_OUT !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall[%0d]: got valid=%b want 0", i, bus.VALID_OUT);
            end
        end
        bus.EN = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0FFF, 16'h0001);
        tick();
        checks++;
        if (bus.VALID_OUT !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got valid=%b want 0", bus.VALID_OUT);
        end
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checks++;
            if ({bus.VALID_OUT, bus.COUT, bus.O, bus.Z} !== {1'b1, want_c[i], want_o[i], FLAGS & want_z[i]}) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got valid=%b cout=%b o=%h z=%b want 1 %b %h %b",
                         i, bus.VALID_OUT, bus.COUT, bus.O, bus.Z, want_c[i], want_o[i], FLAGS & want_z[i]);
            end
        end
        tick();
        checks++;
        if (bus.VALID_OUT !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b want 0", bus.VALID_OUT);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h4444, 16'h0001);
        tick();
        checks++;
        if ({bus.VALID_OUT, bus.O, bus.COUT, bus.V, bus.Z} !== 20'h0) begin
            errors++;
            $display("FAIL midflight_reset: got valid=%b o=%h c=%b v=%b z=%b want all 0",
                     bus.VALID_OUT, bus.O, bus.COUT, bus.V, bus.Z);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.VALID_OUT !== 1'b0) begin
                errors++;
                $display("FAIL midflight_ghost[%0d]: got valid=%b want 0", i, bus.VALID_OUT);
            end
            tick();
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        checks++;
        if ({bus.VALID_OUT, bus.COUT, bus.O} !== {1'b1, 1'b1, 16'h00FF}) begin
            errors++;
            $display("FAIL midflight_after: got valid=%b cout=%b o=%h want 1 1 00ff",
                     bus.VALID_OUT, bus.COUT, bus.O);
        end
    endtask

    initial begin
        rst    = 1'b1;
        bus.EN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        test_reset();
        test_arith();
        test_stall_hold();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; the registered successor to the fixed 4-bit carry-chain subtractor.
- WIDTH-bit operands are split into SLICE-bit slices, with one slice per pipeline stage and the carry registered between stages.
- This gives a short carry chain per cycle at any width, and accepts one operation per cycle.
- Used in datapaths and counters where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits resolved per stage; STAGES = WIDTH/SLICE (SLICE = WIDTH gives a single stage).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  pipeline advance; 0 holds all pipeline state.
- VALID_IN  input  1  operands present this cycle.
- SUB  input  1  0 = add, 1 = subtract.
- CIN  input  1  carry-in (add) / borrow-in (subtract).
- I0  input  WIDTH  operand A.
- I1  input  WIDTH  operand B.
- VALID_OUT  output  1  result present.
- O  output  WIDTH  result.
- COUT  output  1  raw carry out of the MSB slice.
- V  output  1  signed overflow flag (see Optional Feature).
- Z  output  1  result-is-zero flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET).
- Arithmetic, add: {COUT,O} = I0 + I1 + CIN.
- Arithmetic, subtract: {COUT,O} = I0 + ~I1 + ~CIN, i.e. O = I0 - I1 - CIN mod 2^WIDTH. COUT=1 means no borrow (I0 >= I1+CIN unsigned).
- Chain carry-in c0 = CIN XOR SUB. Per slice, B bits are inverted when SUB=1.
- Stage k (0..STAGES-1) computes slice k, bits [k*SLICE +: SLICE], from the operand slice and the registered carry of stage k-1. Stage 0 uses c0.
- Input skew: operand slices for stage k are delayed k cycles. Result de-skew: the slice produced at stage k is delayed STAGES-1-k cycles, so all O bits emerge aligned.
- SUB is carried down the pipe with the operands so flags and the inversion stay with their operation.
- Latency: exactly STAGES enabled cycles from a VALID_IN sample to the matching VALID_OUT/O/COUT. Throughput is 1 op per enabled cycle, in order.
- VALID pipeline: a valid bit travels with each operation. VALID_IN=0 inserts a bubble; O/COUT for bubbles are don't-care but must not raise VALID_OUT.
- EN=0: every pipeline register (data, carry, valid, skew/de-skew) holds. Outputs hold their current values, including VALID_OUT. No operation is lost or duplicated.
- RESET (takes priority over EN): next cycle all registers = 0, so VALID_OUT=0, O=0, COUT=0, V=0, Z=0. In-flight operations are discarded. Operations presented while RESET=1 are dropped.
- The first valid result after reset release appears STAGES enabled cycles after the first sampled VALID_IN=1.
- Elaboration: WIDTH % SLICE != 0 or SLICE < 1 is a fatal elaboration error.
- No combinational path from inputs to outputs when STAGES >= 1; all outputs come from registers.

Optional Feature:
- Macro: ADDSUB_PIPE_FLAGS_EN.
- Defined: V and Z are registered in the final stage, aligned with O.
  - V = carry into MSB XOR carry out of MSB (two's-complement overflow for the selected operation).
  - Z = (O == 0).
- Not defined: V and Z are constant 0 and no flag logic is generated. The ports remain present so instantiations are unchanged.

Test Plan (WIDTH=16, SLICE=4, latency 4, EN=1 unless stated; flag checks require ADDSUB_PIPE_FLAGS_EN):
- Add carry propagation: SUB=0, I0=0x1234, I1=0x0FFF, CIN=0 -> 4 cycles later VALID_OUT=1, O=0x2233, COUT=0, V=0, Z=0.
- Subtract with borrow: SUB=1, I0=0x0005, I1=0x0007, CIN=0 -> O=0xFFFE, COUT=0, V=0, Z=0. Same with CIN=1 -> O=0xFFFD.
- Full-width carry ripple across all slices: SUB=0, I0=0xFFFF, I1=0x0001, CIN=0 -> O=0x0000, COUT=1, Z=1, V=0.
- Signed overflow:
  - SUB=0, 0x7FFF+0x0001 -> O=0x8000, V=1, COUT=0.
  - SUB=1, 0x8000-0x0001 -> O=0x7FFF, V=1, COUT=1.
- Back-to-back with stall: issue 0x0001+0x0001, 0x00FF+0x0001, 0x0FFF+0x0001, 0xFFFF+0x0001 on consecutive cycles, with EN=0 for 2 cycles after the second issue.
  - Required results, in order: 0x0002, 0x0100, 0x1000, 0x0000 (COUT=1).
  - VALID_OUT and O are frozen during the stall; total span is 4+3+2 cycles.
- Reset mid-flight: issue 3 ops, assert RESET for 1 cycle after the 2nd -> next cycle all outputs 0, no results from those ops ever appear. An op issued 1 cycle after release returns 4 cycles later with the correct value.
